// File: rtl/fdd_pkg.sv
// Shared types and helpers for the Disk II track buffer SD sequencer.
// The LBA helper packs 13 sectors per track into consecutive SD blocks.
package fdd_pkg;

   localparam int SECTORS_PER_TRACK = 13;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FLUSH_REQ = 3'd1,
      FLUSH_ACK = 3'd2,
      LOAD_REQ  = 3'd3,
      LOAD_ACK  = 3'd4
   } fdd_state_e;

   // 13*trk built from shifts so no multiplier is inferred
   function automatic logic [31:0] lba_of(input logic [31:0] trk, input logic [3:0] sec);
      return (trk << 3) + (trk << 2) + trk + {28'd0, sec};
   endfunction

endpackage

// File: rtl/fdd_track_sd_ctrl_if.sv
// SD channel request/acknowledge bundle between the track sequencer and the host.
interface fdd_track_sd_ctrl_if #(
   parameter int LBA_W = 32
);
   logic [LBA_W-1:0] sd_lba;
   logic             sd_rd;
   logic             sd_wr;
   logic             sd_ack;

   modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
   modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/fdd_dirty_map.sv
// Per-sector dirty flags with a lowest-set-bit encoder over the flags plus
// any mark arriving this cycle, so a start decision sees same-cycle writes.
module fdd_dirty_map #(
   parameter int N = 13
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr_all,
   input  logic       set_en,
   input  logic [3:0] set_idx,
   input  logic       clr_en,
   input  logic [3:0] clr_idx,
   output logic       any,
   output logic [3:0] idx
);

   logic [N-1:0] bits_r;
   logic [N-1:0] set_vec_s;
   logic [N-1:0] clr_vec_s;
   logic [N-1:0] view_s;

   // decode set/clear strobes into one-hot vectors
   always_comb begin
      set_vec_s = '0;
      clr_vec_s = '0;
      for (int i = 0; i < N; i++) begin
         set_vec_s[i] = set_en && (set_idx == 4'(i));
         clr_vec_s[i] = clr_en && (clr_idx == 4'(i));
      end
   end

   // a fresh mark wins over a clear so a rewritten sector is flushed again
   always_ff @(posedge clk) begin
      if (reset) begin
         bits_r <= '0;
      end else if (clr_all) begin
         bits_r <= '0;
      end else begin
         bits_r <= (bits_r & ~clr_vec_s) | set_vec_s;
      end
   end

   // lowest set bit of the pending view
   always_comb begin
      view_s = bits_r | set_vec_s;
      any    = |view_s;
      idx    = 4'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (view_s[i]) idx = 4'(i);
         else           idx = idx;
      end
   end

endmodule

// File: rtl/fdd_track_sd_ctrl.sv
// Disk II one-track buffer sequencer: writes back dirty sectors of the old
// track, then loads all sectors of the new track over SD channel 0.
module fdd_track_sd_ctrl
   import fdd_pkg::*;
#(
   parameter int SECTORS = SECTORS_PER_TRACK,
   parameter int TRACK_W = 6,
   parameter int LBA_W   = 32
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic [TRACK_W-1:0] track,
   input  logic               img_mounted,
   input  logic               img_size_nz,
   input  logic               img_readonly,
   input  logic               fd_write,
   input  logic [3:0]         fd_sec,
   fdd_track_sd_ctrl_if.master sd,
   output logic [3:0]         track_sec,
   output logic               cpu_wait,
   output logic               loaded
);

   fdd_state_e         state_r, state_n;
   logic [3:0]         sec_r, sec_n;
   logic [TRACK_W-1:0] tgt_r, tgt_n;
   logic [TRACK_W-1:0] cur_track_r, cur_track_n;
   logic               loaded_n;
   logic               mounted_r;
   logic               protect_r;
   logic               old_ack_r;
   logic               ack_rise_s, ack_fall_s;
   logic               mark_en_s, clr_en_s;
   logic               dm_any_s;
   logic [3:0]         dm_idx_s;
   logic [LBA_W-1:0]   lba_s;
   logic               rd_s, wr_s, wait_s;
   logic [3:0]         ts_s;

   assign ack_rise_s = sd.sd_ack && !old_ack_r;
   assign ack_fall_s = !sd.sd_ack && old_ack_r;
   // the CPU is stalled during loads, so any mark seen there is stale
   assign mark_en_s  = fd_write && !protect_r && (32'(fd_sec) < 32'(SECTORS))
                       && (state_r != LOAD_REQ) && (state_r != LOAD_ACK);

   fdd_dirty_map #(.N(SECTORS)) u_dirty (
      .clk     (clk_sys),
      .reset   (reset),
      .clr_all (img_mounted),
      .set_en  (mark_en_s),
      .set_idx (fd_sec),
      .clr_en  (clr_en_s),
      .clr_idx (sec_r),
      .any     (dm_any_s),
      .idx     (dm_idx_s)
   );

   // state and bookkeeping registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r     <= IDLE;
         sec_r       <= 4'd0;
         tgt_r       <= '0;
         cur_track_r <= '0;
         loaded      <= 1'b0;
         mounted_r   <= 1'b0;
         protect_r   <= 1'b0;
         old_ack_r   <= 1'b0;
      end else begin
         state_r     <= state_n;
         sec_r       <= sec_n;
         tgt_r       <= tgt_n;
         cur_track_r <= cur_track_n;
         loaded      <= loaded_n;
         old_ack_r   <= sd.sd_ack;
         if (img_mounted) begin
            mounted_r <= img_size_nz;
            protect_r <= img_readonly;
         end
      end
   end

   // next-state: a mount aborts any transfer and forces a fresh load
   always_comb begin
      state_n     = state_r;
      sec_n       = sec_r;
      tgt_n       = tgt_r;
      cur_track_n = cur_track_r;
      loaded_n    = loaded;
      clr_en_s    = 1'b0;
      if (img_mounted) begin
         state_n  = IDLE;
         sec_n    = 4'd0;
         loaded_n = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (mounted_r && ((track != cur_track_r) || !loaded)) begin
                  tgt_n = track;
                  if (dm_any_s) begin
                     state_n = FLUSH_REQ;
                     sec_n   = dm_idx_s;
                  end else begin
                     state_n = LOAD_REQ;
                     sec_n   = 4'd0;
                  end
               end else begin
                  state_n = IDLE;
               end
            end
            FLUSH_REQ: begin
               if (ack_rise_s) begin
                  clr_en_s = 1'b1;
                  state_n  = FLUSH_ACK;
               end else begin
                  state_n  = FLUSH_REQ;
               end
            end
            FLUSH_ACK: begin
               if (ack_fall_s) begin
                  if (dm_any_s) begin
                     state_n = FLUSH_REQ;
                     sec_n   = dm_idx_s;
                  end else begin
                     state_n = LOAD_REQ;
                     sec_n   = 4'd0;
                  end
               end else begin
                  state_n = FLUSH_ACK;
               end
            end
            LOAD_REQ: begin
               if (ack_rise_s) state_n = LOAD_ACK;
               else            state_n = LOAD_REQ;
            end
            LOAD_ACK: begin
               if (ack_fall_s) begin
                  if (sec_r == 4'(SECTORS - 1)) begin
                     cur_track_n = tgt_r;
                     loaded_n    = 1'b1;
                     state_n     = IDLE;
                  end else begin
                     sec_n   = sec_r + 4'd1;
                     state_n = LOAD_REQ;
                  end
               end else begin
                  state_n = LOAD_ACK;
               end
            end
            default: begin
               state_n = IDLE;
               sec_n   = 4'd0;
            end
         endcase
      end
   end

   // output decode from the next state so every output is a flop
   always_comb begin
      lba_s  = '0;
      rd_s   = 1'b0;
      wr_s   = 1'b0;
      ts_s   = 4'd0;
      wait_s = 1'b0;
      case (state_n)
         IDLE: begin
            wait_s = 1'b0;
         end
         FLUSH_REQ, FLUSH_ACK: begin
            lba_s  = LBA_W'(lba_of(32'(cur_track_r), sec_n));
            wr_s   = (state_n == FLUSH_REQ);
            ts_s   = sec_n;
            wait_s = 1'b1;
         end
         LOAD_REQ, LOAD_ACK: begin
            lba_s  = LBA_W'(lba_of(32'(tgt_n), sec_n));
            rd_s   = (state_n == LOAD_REQ);
            ts_s   = sec_n;
            wait_s = 1'b1;
         end
         default: begin
            wait_s = 1'b0;
         end
      endcase
   end

   // registered SD request and buffer-slot outputs
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sd.sd_lba <= '0;
         sd.sd_rd  <= 1'b0;
         sd.sd_wr  <= 1'b0;
         track_sec <= 4'd0;
         cpu_wait  <= 1'b0;
      end else begin
         sd.sd_lba <= lba_s;
         sd.sd_rd  <= rd_s;
         sd.sd_wr  <= wr_s;
         track_sec <= ts_s;
         cpu_wait  <= wait_s;
      end
   end

endmodule

// File: tb/tb_fdd_track_sd_ctrl.sv
// Directed plus randomized bench for fdd_track_sd_ctrl with an SD host
// responder and a transfer-list reference model.
module tb_fdd_track_sd_ctrl;

   typedef struct {
      bit        wr;
      bit [31:0] lba;
      bit [3:0]  ts;
   } xact_t;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic [5:0] track;
   logic       img_mounted, img_size_nz, img_readonly;
   logic       fd_write;
   logic [3:0] fd_sec;
   logic [3:0] track_sec;
   logic       cpu_wait, loaded;

   fdd_track_sd_ctrl_if #(.LBA_W(32)) sd_bus ();

   fdd_track_sd_ctrl #(.SECTORS(13), .TRACK_W(6), .LBA_W(32)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .track        (track),
      .img_mounted  (img_mounted),
      .img_size_nz  (img_size_nz),
      .img_readonly (img_readonly),
      .fd_write     (fd_write),
      .fd_sec       (fd_sec),
      .sd           (sd_bus),
      .track_sec    (track_sec),
      .cpu_wait     (cpu_wait),
      .loaded       (loaded)
   );

   always #5 clk_sys = ~clk_sys;

   int        n_tests = 0;
   int        n_fail  = 0;
   int        ack_lat = 4;
   int        ack_hi  = 2;
   xact_t     log_q[$];
   xact_t     exp_q[$];
   bit [12:0] m_dirty;
   int        m_cur;
   bit        m_protect;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_sys);
   endtask

   // SD host: acknowledges each request after ack_lat cycles for ack_hi cycles
   initial begin
      xact_t x;
      bit    abort;
      sd_bus.sd_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (!reset && !sd_bus.sd_ack && (sd_bus.sd_rd || sd_bus.sd_wr)) begin
            x.wr  = sd_bus.sd_wr;
            x.lba = sd_bus.sd_lba;
            x.ts  = track_sec;
            check("rd_wr_exclusive", 64'(sd_bus.sd_rd & sd_bus.sd_wr), 64'd0);
            check("wait_in_xfer", 64'(cpu_wait), 64'd1);
            log_q.push_back(x);
            abort = 1'b0;
            for (int i = 1; i < ack_lat && !abort; i++) begin
               @(negedge clk_sys);
               if (reset) abort = 1'b1;
            end
            if (!abort) begin
               sd_bus.sd_ack = 1'b1;
               for (int i = 0; i < ack_hi && !abort; i++) begin
                  @(negedge clk_sys);
                  if (reset) abort = 1'b1;
                  else       check("ts_stable", 64'(track_sec), 64'(x.ts));
               end
            end
            sd_bus.sd_ack = 1'b0;
         end
      end
   end

   task automatic push_loads(input int t);
      for (int s = 0; s < 13; s++) exp_q.push_back('{1'b0, 32'(13 * t + s), 4'(s)});
   endtask

   task automatic push_flush();
      for (int s = 0; s < 13; s++)
         if (m_dirty[s]) exp_q.push_back('{1'b1, 32'(13 * m_cur + s), 4'(s)});
   endtask

   task automatic wait_cpu(input logic val, input int budget, input string tag);
      int n = 0;
      while (cpu_wait !== val && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_wait"}, 64'(cpu_wait), 64'(val));
   endtask

   task automatic compare_log(input string tag);
      check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         check($sformatf("%s_x%0d", tag, i),
               {27'd0, log_q[i].wr, log_q[i].lba, log_q[i].ts},
               {27'd0, exp_q[i].wr, exp_q[i].lba, exp_q[i].ts});
   endtask

   task automatic finish_op(input string tag);
      wait_cpu(1'b1, 20, {tag, "_start"});
      wait_cpu(1'b0, 4000, {tag, "_done"});
      compare_log(tag);
      check({tag, "_loaded"}, 64'(loaded), 64'd1);
      check({tag, "_dirty"}, 64'(dut.u_dirty.bits_r), 64'd0);
   endtask

   task automatic do_write(input int s);
      tick();
      fd_write = 1'b1;
      fd_sec   = 4'(s);
      tick();
      fd_write = 1'b0;
      if (!m_protect && s < 13) m_dirty[s] = 1'b1;
      check($sformatf("dirty_after_wr%0d", s), 64'(dut.u_dirty.bits_r), 64'(m_dirty));
   endtask

   task automatic do_track(input int t);
      exp_q.delete();
      log_q.delete();
      push_flush();
      push_loads(t);
      tick();
      track = 6'(t);
      finish_op($sformatf("trk%0d", t));
      m_dirty = '0;
      m_cur   = t;
   endtask

   task automatic do_mount(input bit ro);
      m_dirty   = '0;
      m_protect = ro;
      exp_q.delete();
      log_q.delete();
      push_loads(int'(track));
      tick();
      img_mounted  = 1'b1;
      img_size_nz  = 1'b1;
      img_readonly = ro;
      tick();
      img_mounted  = 1'b0;
      finish_op($sformatf("mount_ro%0d_trk%0d", ro, track));
      m_cur = int'(track);
   endtask

   initial begin
      int n;
      int t;
      reset = 1'b1; track = 6'd0; img_mounted = 1'b0; img_size_nz = 1'b0;
      img_readonly = 1'b0; fd_write = 1'b0; fd_sec = 4'd0;
      m_dirty = '0; m_cur = 0; m_protect = 1'b0;

      repeat (3) tick();
      check("rst_lba", 64'(sd_bus.sd_lba), 64'd0);
      check("rst_rd_wr", {62'd0, sd_bus.sd_rd, sd_bus.sd_wr}, 64'd0);
      check("rst_ts", 64'(track_sec), 64'd0);
      check("rst_wait_loaded", {62'd0, cpu_wait, loaded}, 64'd0);
      reset = 1'b0;
      repeat (5) tick();
      check("unmounted_idle", {62'd0, cpu_wait, sd_bus.sd_rd}, 64'd0);

      // zero-size image stays idle
      img_mounted = 1'b1; img_size_nz = 1'b0;
      tick();
      img_mounted = 1'b0;
      repeat (20) tick();
      check("empty_img_idle", {61'd0, cpu_wait, sd_bus.sd_rd, loaded}, 64'd0);

      do_mount(1'b0);
      do_write(2); do_write(7); do_write(13); do_write(15);
      do_track(1);

      do_track(0);
      do_mount(1'b1);
      do_write(2); do_write(7);
      do_track(1);

      do_mount(1'b0);
      do_write(4);
      do_mount(1'b0);

      // reset while sector 5 of track 3 is being acknowledged
      exp_q.delete(); log_q.delete();
      tick();
      track = 6'd3;
      n = 0;
      while (!(sd_bus.sd_ack === 1'b1 && track_sec == 4'd5 && sd_bus.sd_wr === 1'b0) && n < 2000) begin
         tick();
         n++;
      end
      check("reset_arm_found", 64'(n < 2000), 64'd1);
      reset = 1'b1;
      tick();
      check("rst_mid_rd", 64'(sd_bus.sd_rd), 64'd0);
      check("rst_mid_wait", 64'(cpu_wait), 64'd0);
      check("rst_mid_loaded", 64'(loaded), 64'd0);
      tick();
      reset = 1'b0;
      m_dirty = '0; m_protect = 1'b0;
      repeat (10) tick();
      check("post_rst_unmounted", {62'd0, cpu_wait, sd_bus.sd_rd}, 64'd0);
      do_mount(1'b0);

      // head moves 0 -> 5 while track 0 is loading
      exp_q.delete(); log_q.delete();
      push_loads(0);
      push_loads(5);
      tick();
      track = 6'd0;
      wait_cpu(1'b1, 20, "mid_start");
      n = 0;
      while (log_q.size() < 3 && n < 500) begin
         tick();
         n++;
      end
      track = 6'd5;
      wait_cpu(1'b0, 2000, "mid_first");
      check("mid_idle_rd", 64'(sd_bus.sd_rd), 64'd0);
      tick();
      check("mid_one_idle_cycle", 64'(cpu_wait), 64'd1);
      check("mid_second_req", {31'd0, sd_bus.sd_rd, sd_bus.sd_lba}, {31'd0, 1'b1, 32'd65});
      wait_cpu(1'b0, 2000, "mid_second");
      compare_log("mid");
      check("mid_loaded", 64'(loaded), 64'd1);
      m_cur = 5;

      // randomized writes, track changes and remounts
      for (int it = 0; it < 8; it++) begin
         ack_lat = int'($urandom_range(1, 6));
         ack_hi  = int'($urandom_range(1, 3));
         n = int'($urandom_range(0, 4));
         for (int k = 0; k < n; k++) do_write(int'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            do_mount(1'($urandom_range(0, 1)));
         end else begin
            t = int'($urandom_range(0, 63));
            if (t == m_cur) t = (t + 1) % 64;
            do_track(t);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
